// File: rtl/ft600_pkg.sv
// Shared constants and types for the FT600 245-mode write path.
package ft600_pkg;

  localparam int FT_DATA_W = 16;
  localparam int FT_BE_W   = 2;

  // oe_n / rd_n are never asserted on the write-only path.
  localparam logic FT_PAD_IDLE = 1'b1;

  // IDLE: wr_n high. WRITE: wr_n low, a word is on the bus.
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } ft_wr_state_e;

endpackage

// File: rtl/ft600_tx_bridge_if.sv
// Sample stream plus FT600 bus pins, as seen by the bridge (slave) and by
// whatever drives the stream and models the FT600 (master).
//
// Handshake: a sample moves on a rising edge where s_valid && s_ready.
// s_ready never depends on s_valid. On the bus side a word moves on a rising
// edge where wr_n == 0 && txe_n == 0; while txe_n is high the word is held.
interface ft600_tx_bridge_if #(
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
) ();

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              txe_n;
  logic              wr_n;
  logic [DATA_W-1:0] data_o;
  logic              data_oe;
  logic [BE_W-1:0]   be_o;
  logic              oe_n;
  logic              rd_n;

  modport slave (
    input  s_valid, s_data, txe_n,
    output s_ready, wr_n, data_o, data_oe, be_o, oe_n, rd_n
  );

  modport master (
    output s_valid, s_data, txe_n,
    input  s_ready, wr_n, data_o, data_oe, be_o, oe_n, rd_n
  );

endinterface

// File: rtl/ft600_tx_bridge_sync_fifo.sv
// Small synchronous FIFO with a combinational head output.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ft600_tx_bridge.sv
// FT600 245-mode write feeder: sample FIFO, one-word hold stage and a
// two-state write FSM presenting one word per clock while txe_n is low.
module ft600_tx_bridge
  import ft600_pkg::*;
#(
  parameter int DATA_W = FT_DATA_W,
  parameter int BE_W   = FT_BE_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  ft600_tx_bridge_if.slave       bus,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output ft_wr_state_e           wr_state,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic              fifo_full, fifo_empty;
  logic              push, pop, drop, accept, load;
  logic [DATA_W-1:0] fifo_head;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  ft_wr_state_e      state_q, state_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              wr_n;

  // full comes from registered occupancy, so a same-cycle pop never frees a
  // slot for a same-cycle push.
  assign bus.s_ready = !fifo_full && !rst;
  assign push        = bus.s_valid && bus.s_ready;
  assign drop        = bus.s_valid && !bus.s_ready && !rst;
  assign accept      = (state_q == WRITE) && !bus.txe_n;
  assign load        = !fifo_empty && (!hold_vld_q || accept);
  assign pop         = load;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.s_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Hold stage: refill from the FIFO head when empty or on accept, else keep
  // the word (a stalled word stays unchanged on the bus).
  always_comb begin
    hold_vld_d = hold_vld_q;
    data_d     = data_q;
    if (load) begin
      hold_vld_d = 1'b1;
      data_d     = fifo_head;
    end else if (accept) begin
      hold_vld_d = 1'b0;
    end
  end

  // Write FSM next state: drive the bus only when enabled, the FT600 has
  // room and the hold stage will hold a word after this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en && !bus.txe_n && hold_vld_d) state_d = WRITE;
      WRITE:   if (!(en && !bus.txe_n && hold_vld_d)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  // All control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      data_q     <= '0;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      data_q     <= data_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign wr_n        = (state_q != WRITE);
  assign bus.wr_n    = wr_n;
  assign bus.data_o  = data_q;
  assign bus.data_oe = ~wr_n;
  assign bus.be_o    = {BE_W{~wr_n}};
  assign bus.oe_n    = FT_PAD_IDLE;
  assign bus.rd_n    = FT_PAD_IDLE;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign wr_state    = state_q;

endmodule

// File: tb/tb_ft600_tx_bridge.sv
// Bench for ft600_tx_bridge: scenario tasks plus a scoreboard of words
// expected on the FT600 bus, popped whenever the bus accepts a word.
module tb_ft600_tx_bridge;
  import ft600_pkg::*;

  localparam int DW = 16;
  localparam int BW = 2;
  localparam int DP = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic          overflow;
  logic [CW-1:0] drop_cnt;
  ft_wr_state_e  wr_state;
  logic [4:0]    fifo_count;

  ft600_tx_bridge_if #(.DATA_W(DW), .BE_W(BW)) bus ();

  ft600_tx_bridge #(
    .DATA_W (DW),
    .BE_W   (BW),
    .DEPTH  (DP),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus.slave),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .wr_state   (wr_state),
    .fifo_count (fifo_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int checks;
  int passes;
  int accepts;
  int low_run;
  int max_run;

  // One clock: at the falling edge observe the bus (a word moves at the next
  // rising edge when wr_n and txe_n are both low), then advance to 1 ns past
  // the rising edge where inputs are changed and outputs checked.
  task automatic step();
    logic [DW-1:0] e;
    @(negedge clk);
    if (!rst && !bus.wr_n && !bus.txe_n) begin
      accepts++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL bus_word: got %h, required none (queue empty)", bus.data_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_o !== e)
          $display("FAIL bus_word: got %h, required %h", bus.data_o, e);
        else
          passes++;
      end
    end
    if (!rst && !bus.wr_n) low_run++;
    else low_run = 0;
    if (low_run > max_run) max_run = low_run;
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one clock; the caller decides whether it is expected.
  task automatic drive_sample(input logic [DW-1:0] d, input bit expect_it);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    if (expect_it) exp_q.push_back(d);
    step();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    step();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: %0d words still pending, required 0", name, exp_q.size());
    else
      passes++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst         = 1'b1;
    en          = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.txe_n   = 1'b1;
    step();
    step();
    checks += 9;
    if (bus.wr_n !== 1'b1) $display("FAIL rst_wr_n: got %b, required 1", bus.wr_n); else passes++;
    if (bus.data_o !== 16'h0) $display("FAIL rst_data_o: got %h, required 0000", bus.data_o); else passes++;
    if (bus.data_oe !== 1'b0) $display("FAIL rst_data_oe: got %b, required 0", bus.data_oe); else passes++;
    if (bus.be_o !== 2'b00) $display("FAIL rst_be_o: got %b, required 00", bus.be_o); else passes++;
    if (bus.s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b, required 0", bus.s_ready); else passes++;
    if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b, required 0", overflow); else passes++;
    if (drop_cnt !== 4'd0) $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); else passes++;
    if (bus.oe_n !== 1'b1) $display("FAIL rst_oe_n: got %b, required 1", bus.oe_n); else passes++;
    if (bus.rd_n !== 1'b1) $display("FAIL rst_rd_n: got %b, required 1", bus.rd_n); else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) $display("FAIL post_rst_s_ready: got %b, required 1", bus.s_ready); else passes++;
  endtask

  task automatic test_single();
    int a0;
    a0        = accepts;
    en        = 1'b1;
    bus.txe_n = 1'b0;
    drive_sample(16'h1234, 1'b1);
    bus.s_valid = 1'b0;
    checks++;
    if (bus.wr_n !== 1'b1) $display("FAIL single_edge_n: got wr_n %b, required 1", bus.wr_n); else passes++;
    step();
    checks += 4;
    if (bus.wr_n !== 1'b0) $display("FAIL single_wr_n: got %b, required 0", bus.wr_n); else passes++;
    if (bus.data_o !== 16'h1234) $display("FAIL single_data_o: got %h, required 1234", bus.data_o); else passes++;
    if (bus.be_o !== 2'b11) $display("FAIL single_be_o: got %b, required 11", bus.be_o); else passes++;
    if (bus.data_oe !== 1'b1) $display("FAIL single_data_oe: got %b, required 1", bus.data_oe); else passes++;
    step();
    checks += 2;
    if (bus.wr_n !== 1'b1) $display("FAIL single_wr_n_release: got %b, required 1", bus.wr_n); else passes++;
    if (accepts - a0 != 1) $display("FAIL single_accepts: got %0d, required 1", accepts - a0); else passes++;
  endtask

  task automatic test_back_to_back();
    int a0;
    a0      = accepts;
    max_run = 0;
    for (int i = 1; i <= 16; i++) drive_sample(16'(i), 1'b1);
    bus.s_valid = 1'b0;
    drain("b2b");
    checks += 3;
    if (accepts - a0 != 16) $display("FAIL b2b_accepts: got %0d, required 16", accepts - a0); else passes++;
    if (max_run != 16) $display("FAIL b2b_wr_n_low_run: got %0d, required 16", max_run); else passes++;
    if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b, required 0", overflow); else passes++;
  endtask

  task automatic test_stall();
    int a0;
    logic [DW-1:0] saved;
    a0        = accepts;
    bus.txe_n = 1'b1;
    for (int i = 0; i < 16; i++) drive_sample(16'h0100 + 16'(i), 1'b1);
    bus.s_valid = 1'b0;
    bus.txe_n   = 1'b0;
    repeat (4) step();
    checks++;
    if (bus.wr_n !== 1'b0) $display("FAIL stall_burst_on: got wr_n %b, required 0", bus.wr_n); else passes++;
    saved     = bus.data_o;
    bus.txe_n = 1'b1;
    step();
    checks += 2;
    if (bus.wr_n !== 1'b1) $display("FAIL stall_wr_n_rise: got %b, required 1", bus.wr_n); else passes++;
    if (bus.data_o !== saved) $display("FAIL stall_data_held: got %h, required %h", bus.data_o, saved); else passes++;
    repeat (4) step();
    bus.txe_n = 1'b0;
    drain("stall");
    checks++;
    if (accepts - a0 != 16) $display("FAIL stall_accepts: got %0d, required 16", accepts - a0); else passes++;
  endtask

  task automatic test_overflow();
    int a0;
    a0        = accepts;
    bus.txe_n = 1'b1;
    // First sample parks in the hold stage so the FIFO itself sees 16 pushes.
    drive_sample(16'h02FF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.s_ready !== (i < 16))
        $display("FAIL ovf_s_ready_%0d: got %b, required %b", i, bus.s_ready, (i < 16));
      else
        passes++;
      drive_sample(16'h0200 + 16'(i), (i < 16));
    end
    bus.s_valid = 1'b0;
    checks += 4;
    if (bus.s_ready !== 1'b0) $display("FAIL ovf_s_ready_full: got %b, required 0", bus.s_ready); else passes++;
    if (drop_cnt !== 4'd4) $display("FAIL ovf_drop_cnt: got %0d, required 4", drop_cnt); else passes++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b, required 1", overflow); else passes++;
    if (fifo_count !== 5'd16) $display("FAIL ovf_fifo_count: got %0d, required 16", fifo_count); else passes++;
    for (int i = 0; i < 20; i++) drive_sample(16'h0E00 + 16'(i), 1'b0);
    bus.s_valid = 1'b0;
    checks++;
    if (drop_cnt !== 4'd15) $display("FAIL ovf_drop_sat: got %0d, required 15", drop_cnt); else passes++;
    bus.txe_n = 1'b0;
    drain("ovf");
    checks += 2;
    if (accepts - a0 != 17) $display("FAIL ovf_accepts: got %0d, required 17", accepts - a0); else passes++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow); else passes++;
  endtask

  task automatic test_enable();
    int a0;
    en        = 1'b0;
    bus.txe_n = 1'b0;
    for (int i = 0; i < 3; i++) drive_sample(16'h0300 + 16'(i), 1'b1);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.wr_n !== 1'b1) $display("FAIL en_gated_wr_n_%0d: got %b, required 1", i, bus.wr_n); else passes++;
    end
    a0      = accepts;
    max_run = 0;
    en      = 1'b1;
    drain("en");
    checks += 2;
    if (accepts - a0 != 3) $display("FAIL en_accepts: got %0d, required 3", accepts - a0); else passes++;
    if (max_run != 3) $display("FAIL en_consecutive: got %0d, required 3", max_run); else passes++;
  endtask

  task automatic test_reset_mid_burst();
    int a0;
    en        = 1'b1;
    bus.txe_n = 1'b0;
    for (int i = 0; i < 8; i++) drive_sample(16'h0400 + 16'(i), 1'b1);
    checks++;
    if (bus.wr_n !== 1'b0) $display("FAIL rmb_burst_on: got wr_n %b, required 0", bus.wr_n); else passes++;
    bus.s_valid = 1'b0;
    rst         = 1'b1;
    exp_q.delete();
    step();
    checks += 5;
    if (bus.wr_n !== 1'b1) $display("FAIL rmb_wr_n: got %b, required 1", bus.wr_n); else passes++;
    if (bus.s_ready !== 1'b0) $display("FAIL rmb_s_ready: got %b, required 0", bus.s_ready); else passes++;
    if (drop_cnt !== 4'd0) $display("FAIL rmb_drop_cnt: got %0d, required 0", drop_cnt); else passes++;
    if (overflow !== 1'b0) $display("FAIL rmb_overflow: got %b, required 0", overflow); else passes++;
    if (fifo_count !== 5'd0) $display("FAIL rmb_fifo_count: got %0d, required 0", fifo_count); else passes++;
    rst = 1'b0;
    a0  = accepts;
    drive_sample(16'hBEEF, 1'b1);
    bus.s_valid = 1'b0;
    drain("rmb");
    checks++;
    if (accepts - a0 != 1) $display("FAIL rmb_accepts: got %0d, required 1", accepts - a0); else passes++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks  = 0;
    passes  = 0;
    accepts = 0;
    low_run = 0;
    max_run = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_enable();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
